// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// Default instruction and PC widths, plus the queue entry layout.
package inst_queue_pkg;

   localparam int INST_BUS_W      = 32;
   localparam int INST_ADDR_BUS_W = 32;

   typedef struct packed {
      logic [INST_ADDR_BUS_W-1:0] pc;
      logic [INST_BUS_W-1:0]      inst;
   } inst_queue_entry_t;

endpackage

// File: rtl/inst_queue_chk.sv
// Protocol checker for inst_queue: fetch slot valids must be contiguous from slot 0.
module inst_queue_chk #(
   parameter int IN_WIDTH = 2
) (
   input logic                clk,
   input logic                rst,
   input logic [IN_WIDTH-1:0] fetch_valid
);

   fetch_valid_contiguous: assert property (@(posedge clk) disable iff (!rst)
      ((fetch_valid & (fetch_valid + IN_WIDTH'(1))) == IN_WIDTH'(0)));

endmodule

// File: rtl/inst_queue_ram.sv
// Instruction queue storage: DEPTH entries, IN_WIDTH write ports, OUT_WIDTH
// asynchronous read ports. Data is never reset.
module inst_queue_ram #(
   parameter int DEPTH     = 8,
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int ENT_W     = 64,
   localparam int IDX_W    = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic [IN_WIDTH-1:0]        wr_en,
   input  logic [IN_WIDTH*IDX_W-1:0]  wr_addr,
   input  logic [IN_WIDTH*ENT_W-1:0]  wr_data,
   input  logic [OUT_WIDTH*IDX_W-1:0] rd_addr,
   output logic [OUT_WIDTH*ENT_W-1:0] rd_data
);

   logic [ENT_W-1:0] mem_r [DEPTH];

   // Per-slot writes; the top guarantees distinct addresses within a cycle.
   always_ff @(posedge clk) begin
      for (int k = 0; k < IN_WIDTH; k++) begin
         if (wr_en[k]) begin
            mem_r[wr_addr[k*IDX_W +: IDX_W]] <= wr_data[k*ENT_W +: ENT_W];
         end
      end
   end

   // Asynchronous read ports.
   always_comb begin
      rd_data = '0;
      for (int j = 0; j < OUT_WIDTH; j++) begin
         rd_data[j*ENT_W +: ENT_W] = mem_r[rd_addr[j*IDX_W +: IDX_W]];
      end
   end

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular FIFO with
// multi-slot push/pop and one-cycle flush. Optional INST_QUEUE_BYPASS_EN adds
// a same-cycle fetch-to-decode path when the queue is empty.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int DATA_W    = INST_BUS_W,
   parameter int ADDR_W    = INST_ADDR_BUS_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IN_WIDTH-1:0]           fetch_valid_i,
   input  logic [IN_WIDTH*ADDR_W-1:0]    fetch_pc_i,
   input  logic [IN_WIDTH*DATA_W-1:0]    fetch_inst_i,
   output logic                          fetch_ready_o,
   input  logic                          flush_i,
   input  logic                          dec_ready_i,
   output logic [OUT_WIDTH-1:0]          dec_valid_o,
   output logic [OUT_WIDTH*ADDR_W-1:0]   dec_pc_o,
   output logic [OUT_WIDTH*DATA_W-1:0]   dec_inst_o,
   output logic [$clog2(DEPTH+1)-1:0]    count_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int ENT_W = ADDR_W + DATA_W;
   localparam int BYP_W = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;

   logic [PTR_W-1:0]           head_r, tail_r;
   logic [PTR_W-1:0]           count_s, n_push_s, n_pop_s, n_skip_s;
   logic                       fetch_ready_s, bypass_s;
   logic [IN_WIDTH-1:0]        wr_en_s;
   logic [IN_WIDTH*IDX_W-1:0]  wr_addr_s;
   logic [IN_WIDTH*ENT_W-1:0]  wr_data_s;
   logic [OUT_WIDTH*IDX_W-1:0] rd_addr_s;
   logic [OUT_WIDTH*ENT_W-1:0] rd_data_s;

   // Extra pointer MSB makes count = DEPTH distinguishable from empty.
   assign count_s       = tail_r - head_r;
   assign fetch_ready_s = rst && ((PTR_W'(DEPTH) - count_s) >= PTR_W'(IN_WIDTH));
   assign fetch_ready_o = fetch_ready_s;
   assign count_o       = rst ? CNT_W'(count_s) : CNT_W'(0);

`ifdef INST_QUEUE_BYPASS_EN
   assign bypass_s = (count_s == PTR_W'(0)) && !flush_i && fetch_ready_s;
`else
   assign bypass_s = 1'b0;
`endif

   // Push/pop amounts; bypassed slots consumed by decode are skipped when storing.
   always_comb begin
      n_push_s = '0;
      for (int k = 0; k < IN_WIDTH; k++) begin
         n_push_s = n_push_s + PTR_W'(fetch_valid_i[k]);
      end
      if (!fetch_ready_s || flush_i) begin
         n_push_s = '0;
      end else begin
         n_push_s = n_push_s;
      end
      if (bypass_s && dec_ready_i) begin
         n_skip_s = (n_push_s < PTR_W'(OUT_WIDTH)) ? n_push_s : PTR_W'(OUT_WIDTH);
      end else begin
         n_skip_s = '0;
      end
      if (dec_ready_i) begin
         n_pop_s = (count_s < PTR_W'(OUT_WIDTH)) ? count_s : PTR_W'(OUT_WIDTH);
      end else begin
         n_pop_s = '0;
      end
   end

   // Per-slot storage addressing with mod-DEPTH wrap.
   always_comb begin
      wr_en_s   = '0;
      wr_addr_s = '0;
      wr_data_s = '0;
      rd_addr_s = '0;
      for (int k = 0; k < IN_WIDTH; k++) begin
         wr_en_s[k] = fetch_ready_s && !flush_i && fetch_valid_i[k] && (PTR_W'(k) >= n_skip_s);
         wr_addr_s[k*IDX_W +: IDX_W] = IDX_W'(tail_r + PTR_W'(k) - n_skip_s);
         wr_data_s[k*ENT_W +: ENT_W] = {fetch_pc_i[k*ADDR_W +: ADDR_W], fetch_inst_i[k*DATA_W +: DATA_W]};
      end
      for (int j = 0; j < OUT_WIDTH; j++) begin
         rd_addr_s[j*IDX_W +: IDX_W] = IDX_W'(head_r + PTR_W'(j));
      end
   end

   inst_queue_ram #(
      .DEPTH     (DEPTH),
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .ENT_W     (ENT_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .wr_addr (wr_addr_s),
      .wr_data (wr_data_s),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   inst_queue_chk #(.IN_WIDTH(IN_WIDTH)) u_chk (
      .clk         (clk),
      .rst         (rst),
      .fetch_valid (fetch_valid_i)
   );

   // Decode view: storage head in FWFT order, fetch slots when bypassing, zero in reset.
   always_comb begin
      dec_valid_o = '0;
      dec_pc_o    = '0;
      dec_inst_o  = '0;
      for (int j = 0; j < OUT_WIDTH; j++) begin
         if (!rst) begin
            dec_valid_o[j] = 1'b0;
         end else if (bypass_s && (j < BYP_W)) begin
            dec_valid_o[j]                = fetch_valid_i[j];
            dec_pc_o[j*ADDR_W +: ADDR_W]  = fetch_pc_i[j*ADDR_W +: ADDR_W];
            dec_inst_o[j*DATA_W +: DATA_W] = fetch_inst_i[j*DATA_W +: DATA_W];
         end else begin
            dec_valid_o[j] = (PTR_W'(j) < count_s);
            {dec_pc_o[j*ADDR_W +: ADDR_W], dec_inst_o[j*DATA_W +: DATA_W]} = rd_data_s[j*ENT_W +: ENT_W];
         end
      end
   end

   // Pointer state; flush wins over push and pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_r <= '0;
         tail_r <= '0;
      end else if (flush_i) begin
         head_r <= '0;
         tail_r <= '0;
      end else begin
         head_r <= head_r + n_pop_s;
         tail_r <= tail_r + n_push_s - n_skip_s;
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a PC scoreboard of queued entries.
`timescale 1ns/1ps
module tb_inst_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  fetch_valid;
   logic [63:0] fetch_pc, fetch_inst;
   logic        fetch_ready, flush, dec_ready;
   logic [1:0]  dec_valid;
   logic [63:0] dec_pc, dec_inst;
   logic [3:0]  count;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb[$];
   logic [31:0] next_pc;
   logic        took;
   int          pushed;

   always #5 clk = ~clk;

   inst_queue dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_valid_i (fetch_valid),
      .fetch_pc_i    (fetch_pc),
      .fetch_inst_i  (fetch_inst),
      .fetch_ready_o (fetch_ready),
      .flush_i       (flush),
      .dec_ready_i   (dec_ready),
      .dec_valid_o   (dec_valid),
      .dec_pc_o      (dec_pc),
      .dec_inst_o    (dec_inst),
      .count_o       (count)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hdead_beef;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pair(input logic [1:0] v, input logic [31:0] pc0);
      fetch_valid = v;
      fetch_pc    = {pc0 + 32'd4, pc0};
      fetch_inst  = {inst_of(pc0 + 32'd4), inst_of(pc0)};
   endtask

   // Compare visible queue state with the scoreboard (no popping).
   task automatic check_state(input string tag);
      int n;
      logic [1:0] ev;
      n  = sb.size();
      ev = (n >= 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
      chk({tag, "_count"}, 64'(count), 64'(n));
      chk({tag, "_valid"}, 64'(dec_valid), 64'(ev));
      chk({tag, "_ready"}, 64'(fetch_ready), 64'((8 - n) >= 2));
      for (int j = 0; j < 2; j++) begin
         if (j < n) begin
            chk({tag, "_pc"}, 64'(dec_pc[j*32 +: 32]), 64'(sb[j]));
            chk({tag, "_inst"}, 64'(dec_inst[j*32 +: 32]), 64'(inst_of(sb[j])));
         end
      end
   endtask

   // One clock of stimulus; the scoreboard follows the queue contract.
   task automatic cycle(input string tag, input logic rdy, input logic [1:0] v,
                        input logic [31:0] pc0, input logic fl, output logic acc);
      int  n_pop;
      logic [1:0] store;
      dec_ready = rdy;
      flush     = fl;
      drive_pair(v, pc0);
      acc   = !fl && ((8 - sb.size()) >= 2);
      n_pop = (rdy && !fl) ? ((sb.size() < 2) ? sb.size() : 2) : 0;
      store = v;
`ifdef INST_QUEUE_BYPASS_EN
      if (acc && rdy && (sb.size() == 0) && (v != 2'b00)) begin
         #1;
         chk({tag, "_byp_valid"}, 64'(dec_valid), 64'(v));
         chk({tag, "_byp_pc0"}, 64'(dec_pc[31:0]), 64'(pc0));
         chk({tag, "_byp_count"}, 64'(count), 64'd0);
         store = 2'b00;
      end
`endif
      if (fl) begin
         sb.delete();
      end else begin
         repeat (n_pop) void'(sb.pop_front());
         if (acc) begin
            for (int k = 0; k < 2; k++) begin
               if (store[k]) sb.push_back(pc0 + 32'(4 * k));
            end
         end
      end
      tick();
      fetch_valid = 2'b00;
      flush       = 1'b0;
      dec_ready   = 1'b0;
      check_state(tag);
   endtask

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      dec_ready = 1'b0;
      drive_pair(2'b11, 32'h1c00_0000);

      // Reset held with fetch activity.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_count", 64'(count), 64'd0);
         chk("rst_valid", 64'(dec_valid), 64'd0);
         chk("rst_ready", 64'(fetch_ready), 64'd0);
      end
      fetch_valid = 2'b00;
      rst = 1'b1;
      #1;
      chk("rel_ready", 64'(fetch_ready), 64'd1);
      chk("rel_valid", 64'(dec_valid), 64'd0);

      // Fill to full, then a refused fifth pair.
      for (int i = 0; i < 4; i++) begin
         cycle("fill", 1'b0, 2'b11, 32'h1c00_0000 + 32'(8 * i), 1'b0, took);
      end
      chk("full_count", 64'(count), 64'd8);
      chk("full_ready", 64'(fetch_ready), 64'd0);
      cycle("refused", 1'b0, 2'b11, 32'h1c00_0020, 1'b0, took);

      // Drain in order.
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", 64'(dec_pc[31:0]), 64'(32'h1c00_0000 + 32'(8 * i)));
         cycle("drain", 1'b1, 2'b00, 32'h0, 1'b0, took);
      end
      chk("empty_count", 64'(count), 64'd0);

      // Partial single-slot push.
      cycle("partial", 1'b0, 2'b01, 32'h1c00_0100, 1'b0, took);
      chk("partial_pc", 64'(dec_pc[31:0]), 64'h1c00_0100);

      // Flush collides with push and pop.
      cycle("pre_flush", 1'b0, 2'b11, 32'h1c00_0200, 1'b0, took);
      cycle("pre_flush", 1'b0, 2'b11, 32'h1c00_0210, 1'b0, took);
      chk("pre_flush_count", 64'(count), 64'd5);
      cycle("flush", 1'b1, 2'b11, 32'h1c00_0280, 1'b1, took);
      chk("flush_count", 64'(count), 64'd0);
      cycle("post_flush", 1'b0, 2'b11, 32'h1c00_0300, 1'b0, took);
      chk("post_flush_pc", 64'(dec_pc[31:0]), 64'h1c00_0300);
      for (int i = 0; i < 4; i++) cycle("post_flush_drain", 1'b1, 2'b00, 32'h0, 1'b0, took);

      // Continuous traffic with random decode backpressure, wrapping the pointers.
      next_pc = 32'h1c00_1000;
      pushed  = 0;
      for (int i = 0; i < 40; i++) begin
         cycle("wrap", ($urandom_range(0, 3) != 0), 2'b11, next_pc, 1'b0, took);
         if (took) begin
            next_pc = next_pc + 32'd8;
            pushed  = pushed + 2;
         end
      end
      for (int i = 0; i < 6; i++) cycle("wrap_drain", 1'b1, 2'b00, 32'h0, 1'b0, took);
      chk("wrap_empty", 64'(count), 64'd0);

`ifdef INST_QUEUE_BYPASS_EN
      cycle("bypass", 1'b1, 2'b11, 32'h1c00_0400, 1'b0, took);
      chk("bypass_count", 64'(count), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
